// File: rtl/tf_stage_sched.sv
// Twiddle-factor stage scheduler: steps through NTT butterfly stages, emits per-lane TF
// exponent indices, delays the TF write enable and registers/masks returned TF values.
module tf_stage_sched #(
  parameter int LOG_DEGREE = 16,
  parameter int RADIX_K1   = 4,
  parameter int RADIX_K2   = 4,
  parameter int LANES      = 15,
  parameter int LAST_LANES = 4,
  parameter int D_WIDTH    = 64,
  parameter int IDX_W      = 5,
  parameter int WEN_DELAY  = 3,
  parameter int NUM_STAGES = 3,
  localparam int SW        = (NUM_STAGES > 0) ? $clog2(NUM_STAGES + 1) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       stage_done,
  input  logic                       tf_wen,
  input  logic [LANES*D_WIDTH-1:0]   tf_in,
  input  logic                       tf_in_valid,
  output logic                       busy,
  output logic                       last_stage,
  output logic [SW-1:0]              stage_l,
  output logic [LANES*IDX_W-1:0]     idx_out,
  output logic                       idx_valid,
  output logic                       tf_wen_dly,
  output logic [LANES*D_WIDTH-1:0]   tf_out,
  output logic                       tf_out_valid,
  output logic                       done
);

  typedef enum logic [1:0] {IDLE, RUN, LAST, DONE} state_e;

  state_e                   state_q, state_d;
  logic [SW-1:0]            stage_q, stage_d;
  logic                     busy_q, last_q, done_q, idx_vld_q, tf_vld_q;
  logic [LANES*IDX_W-1:0]   idx_q, idx_d;
  logic [LANES*D_WIDTH-1:0] tf_q, tf_d;

  // floor(log2(v)) for the 1-based lane number
  function automatic logic [IDX_W-1:0] flog2(input int unsigned v);
    flog2 = '0;
    for (int b = 0; b < 32; b++) begin
      if (v >= (32'd1 << b)) flog2 = IDX_W'(b);
    end
  endfunction

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (NUM_STAGES == 0) begin
            state_d = LAST;
            stage_d = SW'(NUM_STAGES);
          end else begin
            state_d = RUN;
            stage_d = '0;
          end
        end
      end
      RUN: begin
        if (stage_done) begin
          if (stage_q == SW'(NUM_STAGES - 1)) begin
            state_d = LAST;
            stage_d = SW'(NUM_STAGES);
          end else begin
            stage_d = stage_q + 1'b1;
          end
        end
      end
      LAST: begin
        if (stage_done) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // Indices follow the registered state, so they trail a stage change by one cycle
  always_comb begin
    idx_d = idx_q;
    for (int i = 1; i <= LANES; i++) begin
      if (state_q == RUN) begin
        idx_d[(i-1)*IDX_W +: IDX_W] = IDX_W'(LOG_DEGREE) - IDX_W'(RADIX_K1) * IDX_W'(stage_q)
                                      - flog2(i);
      end else if (state_q == LAST) begin
        idx_d[(i-1)*IDX_W +: IDX_W] = (i == 1) ? IDX_W'(RADIX_K2) : '0;
      end
    end
  end

  always_comb begin
    tf_d = tf_in;
    for (int i = 0; i < LANES; i++) begin
      if (last_q && i >= LAST_LANES) tf_d[i*D_WIDTH +: D_WIDTH] = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      stage_q   <= '0;
      busy_q    <= 1'b0;
      last_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
      idx_vld_q <= 1'b0;
      tf_q      <= '0;
      tf_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage_q   <= stage_d;
      busy_q    <= (state_d == RUN) || (state_d == LAST);
      last_q    <= (state_d == LAST);
      done_q    <= (state_d == DONE);
      idx_q     <= idx_d;
      idx_vld_q <= busy_q;
      tf_vld_q  <= tf_in_valid;
      if (tf_in_valid) tf_q <= tf_d;
    end
  end

  generate
    if (WEN_DELAY == 0) begin : g_wen_pass
      assign tf_wen_dly = tf_wen;
    end else begin : g_wen_dly
      logic [WEN_DELAY-1:0] wen_sr_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) wen_sr_q <= '0;
        else     wen_sr_q <= (wen_sr_q << 1) | WEN_DELAY'(tf_wen);
      end
      assign tf_wen_dly = wen_sr_q[WEN_DELAY-1];
    end
  endgenerate

  assign busy         = busy_q;
  assign last_stage   = last_q;
  assign stage_l      = stage_q;
  assign done         = done_q;
  assign idx_out      = idx_q;
  assign idx_valid    = idx_vld_q;
  assign tf_out       = tf_q;
  assign tf_out_valid = tf_vld_q;

endmodule

// File: tb/tb_tf_stage_sched.sv
// Directed bench for tf_stage_sched: stage/index walk table plus reset, masking and wen-delay sequences.
module tb_tf_stage_sched;
  localparam int LANES = 15;
  localparam int DW    = 64;
  localparam int IW    = 5;

  logic clk = 1'b0;
  logic rst, start, stage_done, tf_wen, tf_in_valid;
  logic [LANES*DW-1:0] tf_in;
  logic busy, last_stage, idx_valid, tf_wen_dly, tf_out_valid, done;
  logic [1:0] stage_l;
  logic [LANES*IW-1:0] idx_out;
  logic [LANES*DW-1:0] tf_out;
  logic busy0, last0, ivld0, dly0, tfv0, done0;
  logic [1:0] stage0;
  logic [LANES*IW-1:0] idx0;
  logic [LANES*DW-1:0] tfo0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  tf_stage_sched dut (
    .clk(clk), .rst(rst), .start(start), .stage_done(stage_done), .tf_wen(tf_wen),
    .tf_in(tf_in), .tf_in_valid(tf_in_valid), .busy(busy), .last_stage(last_stage),
    .stage_l(stage_l), .idx_out(idx_out), .idx_valid(idx_valid), .tf_wen_dly(tf_wen_dly),
    .tf_out(tf_out), .tf_out_valid(tf_out_valid), .done(done)
  );

  tf_stage_sched #(.WEN_DELAY(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .stage_done(stage_done), .tf_wen(tf_wen),
    .tf_in(tf_in), .tf_in_valid(tf_in_valid), .busy(busy0), .last_stage(last0),
    .stage_l(stage0), .idx_out(idx0), .idx_valid(ivld0), .tf_wen_dly(dly0),
    .tf_out(tfo0), .tf_out_valid(tfv0), .done(done0)
  );

  typedef struct {
    logic start;
    logic sd;
    int   gap;
    logic busy;
    logic last;
    int   stage;
    logic done;
    logic ivld;
    int   e1, e2, e4, e8;
  } vec_t;

  vec_t tbl[15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [LANES*IW-1:0] exp_idx(input int e1, input int e2, input int e4, input int e8);
    logic [LANES*IW-1:0] v;
    v = '0;
    for (int i = 1; i <= LANES; i++) begin
      v[(i-1)*IW +: IW] = IW'((i >= 8) ? e8 : (i >= 4) ? e4 : (i >= 2) ? e2 : e1);
    end
    return v;
  endfunction

  function automatic logic [LANES*DW-1:0] exp_tf(input int keep);
    logic [LANES*DW-1:0] v;
    v = '0;
    for (int i = 0; i < keep; i++) v[i*DW +: DW] = 64'hA5;
    return v;
  endfunction

  initial begin
    //           st sd gap  busy last stg done iv   e1  e2  e4  e8
    tbl[0]  = '{1'b0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0,  0,  0,  0,  0};
    tbl[1]  = '{1'b1, 1'b1, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0,  0,  0,  0,  0};
    tbl[2]  = '{1'b0, 1'b0, 8, 1'b1, 1'b0, 0, 1'b0, 1'b1, 16, 15, 14, 13};
    tbl[3]  = '{1'b1, 1'b0, 0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 16, 15, 14, 13};
    tbl[4]  = '{1'b0, 1'b1, 0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 16, 15, 14, 13};
    tbl[5]  = '{1'b0, 1'b0, 0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 12, 11, 10,  9};
    tbl[6]  = '{1'b0, 1'b1, 9, 1'b1, 1'b0, 2, 1'b0, 1'b1,  8,  7,  6,  5};
    tbl[7]  = '{1'b0, 1'b1, 0, 1'b1, 1'b1, 3, 1'b0, 1'b1,  8,  7,  6,  5};
    tbl[8]  = '{1'b0, 1'b0, 5, 1'b1, 1'b1, 3, 1'b0, 1'b1,  4,  0,  0,  0};
    tbl[9]  = '{1'b0, 1'b1, 0, 1'b0, 1'b0, 3, 1'b1, 1'b1,  4,  0,  0,  0};
    tbl[10] = '{1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0,  4,  0,  0,  0};
    tbl[11] = '{1'b0, 1'b1, 3, 1'b0, 1'b0, 0, 1'b0, 1'b0,  4,  0,  0,  0};
    tbl[12] = '{1'b1, 1'b1, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0,  4,  0,  0,  0};
    tbl[13] = '{1'b0, 1'b1, 0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 16, 15, 14, 13};
    tbl[14] = '{1'b0, 1'b1, 0, 1'b1, 1'b0, 2, 1'b0, 1'b1, 12, 11, 10,  9};

    rst = 1'b1; start = 1'b0; stage_done = 1'b0; tf_wen = 1'b0;
    tf_in_valid = 1'b0; tf_in = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stage", stage_l, 0);
    chk("rst_idx", idx_out, 0);
    chk("rst_tfout", tf_out, 0);
    chk("rst_wendly", tf_wen_dly, 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    for (int r = 0; r < 15; r++) begin
      start = tbl[r].start;
      stage_done = tbl[r].sd;
      step();
      start = 1'b0;
      stage_done = 1'b0;
      repeat (tbl[r].gap) step();
      chk($sformatf("row%0d_busy", r), busy, tbl[r].busy);
      chk($sformatf("row%0d_last", r), last_stage, tbl[r].last);
      chk($sformatf("row%0d_stage", r), stage_l, tbl[r].stage);
      chk($sformatf("row%0d_done", r), done, tbl[r].done);
      chk($sformatf("row%0d_ivld", r), idx_valid, tbl[r].ivld);
      chk($sformatf("row%0d_idx", r), idx_out,
          exp_idx(tbl[r].e1, tbl[r].e2, tbl[r].e4, tbl[r].e8));
    end

    // Asynchronous reset in RUN at stage 2, then restart
    rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_stage", stage_l, 0);
    chk("arst_ivld", idx_valid, 0);
    chk("arst_idx", idx_out, 0);
    rst = 1'b0;
    step();
    chk("arst_nodone", done, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_busy", busy, 1);
    chk("restart_stage", stage_l, 0);

    // Capture in RUN: all lanes pass
    for (int i = 0; i < LANES; i++) tf_in[i*DW +: DW] = 64'hA5;
    tf_in_valid = 1'b1;
    step();
    tf_in_valid = 1'b0;
    chk("run_tfvld", tf_out_valid, 1);
    chk("run_tfout", tf_out, exp_tf(15));
    step();
    chk("hold_tfvld", tf_out_valid, 0);
    chk("hold_tfout", tf_out, exp_tf(15));

    stage_done = 1'b1;
    repeat (3) step();
    stage_done = 1'b0;
    chk("mask_last", last_stage, 1);
    tf_in_valid = 1'b1;
    step();
    tf_in_valid = 1'b0;
    chk("last_tfvld", tf_out_valid, 1);
    chk("last_tfout", tf_out, exp_tf(4));
    stage_done = 1'b1;
    step();
    stage_done = 1'b0;
    chk("end_done", done, 1);
    step();
    chk("end_done_clr", done, 0);
    chk("end_busy", busy, 0);

    // tf_wen delay: 3 cycles on dut, passthrough on dut0
    tf_wen = 1'b1;
    #1;
    chk("wen0_pass_hi", dly0, 1);
    chk("wen_d0", tf_wen_dly, 0);
    step();
    tf_wen = 1'b0;
    #1;
    chk("wen0_pass_lo", dly0, 0);
    chk("wen_d1", tf_wen_dly, 0);
    step();
    chk("wen_d2", tf_wen_dly, 0);
    step();
    chk("wen_d3", tf_wen_dly, 1);
    step();
    chk("wen_d4", tf_wen_dly, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tf_stage_sched.md
Name: tf_stage_sched

Overview:
- Parametrised twiddle-factor stage scheduler for the NTT datapath.
- Walks automatically through all butterfly stages and generates per-lane TF exponent indices for each stage, including the dedicated last (radix-k2) stage.
- Delays the TF write enable by a programmable depth.
- Registers and masks the per-lane TF values returned by the downstream TF generator.
- Sits between the NTT control FSM and the TF generator, replacing hard-wired 15-lane, fixed-delay index logic.

Parameters:
- LOG_DEGREE, 16, log2 of polynomial degree.
- RADIX_K1, 4, log2 radix of normal stages; lanes = 2^RADIX_K1-1.
- RADIX_K2, 4, log2 radix of last stage; must equal LOG_DEGREE mod RADIX_K1, or RADIX_K1 when the remainder is 0.
- LANES, 15, TF lanes; equals 2^RADIX_K1-1.
- LAST_LANES, 4, lanes passed through in last stage; the rest are zeroed.
- D_WIDTH, 64, TF data width.
- IDX_W, 5, index width; must be at least clog2(LOG_DEGREE+1).
- WEN_DELAY, 3, tf_wen delay in cycles (0 = combinational passthrough).
- NUM_STAGES, 3, normal stages; equals (LOG_DEGREE-RADIX_K2)/RADIX_K1.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous, active-high reset.
- start, in, 1, single-cycle pulse; begins a transform.
- stage_done, in, 1, single-cycle pulse; current stage finished.
- tf_wen, in, 1, TF write enable from control.
- tf_in, in, LANES*D_WIDTH, TF values from generator; lane i at bits [i*D_WIDTH +: D_WIDTH], i=0..LANES-1.
- tf_in_valid, in, 1, tf_in qualifier.
- busy, out, 1, high in RUN or LAST.
- last_stage, out, 1, high in LAST.
- stage_l, out, clog2(NUM_STAGES+1), current stage number.
- idx_out, out, LANES*IDX_W, per-lane exponent indices.
- idx_valid, out, 1, idx_out qualifier.
- tf_wen_dly, out, 1, delayed tf_wen.
- tf_out, out, LANES*D_WIDTH, registered, masked TF values.
- tf_out_valid, out, 1, tf_out qualifier.
- done, out, 1, one-cycle pulse at end of transform.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, stage_l 0, delay line cleared. All outputs are registered, except tf_wen_dly when WEN_DELAY=0.
- FSM states: IDLE, RUN, LAST, DONE.
  - IDLE -> RUN on start; stage_l <= 0.
  - RUN: stage_done with stage_l < NUM_STAGES-1 -> stage_l+1, stay in RUN. stage_done with stage_l = NUM_STAGES-1 -> LAST, stage_l <= NUM_STAGES.
  - LAST: stage_done -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE; stage_l <= 0.
  - If NUM_STAGES=0, IDLE goes directly to LAST on start.
- start while not IDLE is ignored. stage_done in IDLE or DONE is ignored. start and stage_done together in IDLE: start wins.
- Index generation, lane i (1-based):
  - Normal stage: idx = LOG_DEGREE - RADIX_K1*stage_l - floor(log2(i)).
  - LAST: lane 1 idx = RADIX_K2; all other lanes 0.
  - Arithmetic is unsigned at IDX_W; parameter legality guarantees no underflow.
- idx_out and idx_valid update in the cycle after the state or stage_l change; idx_valid = busy delayed one cycle. In IDLE/DONE, idx_out is held at its last value and idx_valid is 0.
- tf_wen_dly: shift register of length WEN_DELAY. Independent of FSM state; runs continuously and is not cleared by start.
- tf_out: on tf_in_valid, capture tf_in; when last_stage=1 at the capture cycle, lanes LAST_LANES+1..LANES are forced to 0. tf_out_valid = tf_in_valid delayed 1 cycle. tf_out holds its value when tf_in_valid=0.
- Asynchronous reset mid-transform returns everything to reset values immediately; no done pulse is produced.

Test Plan:
- Reset check: assert rst mid-RUN with stage_l=2 -> all outputs 0 asynchronously, FSM IDLE; the next start restarts at stage_l=0.
- Index sweep: start, then stage_done every 10 cycles.
  - stage 0: lane1=16, lanes2-3=15, lanes4-7=14, lanes8-15=13.
  - stage 1: 12/11/10/9.
  - stage 2: 8/7/6/5.
  - LAST: lane1=4, others 0.
  - Then done pulses once, 1 cycle after the 4th stage_done; busy drops.
- Write-enable delay: tf_wen pulse at cycle 5 -> tf_wen_dly at cycle 8. Rebuild with WEN_DELAY=0 -> same-cycle passthrough.
- Last-stage masking: in LAST, tf_in all lanes = 64'hA5, tf_in_valid=1 -> next cycle lanes1-4 = 64'hA5, lanes5-15 = 0, tf_out_valid=1. The same stimulus in RUN -> all 15 lanes = 64'hA5.
- Protocol corners:
  - start during RUN -> ignored, stage_l unchanged.
  - stage_done in IDLE -> no state change.
  - start and stage_done in the same IDLE cycle -> RUN with stage_l=0.
